// File: rtl/dbus_uncached_bridge_pkg.sv
// Shared bus types and constants for the uncached data-bus bridge.
// Defines the CPU data bus, the single-beat cache bus and the bridge state encoding.
package dbus_uncached_bridge_pkg;

    typedef logic [1:0]  u2;
    typedef logic [7:0]  u8;
    typedef logic [63:0] u64;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Encoded as beats minus one, AXI style.
    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    localparam int unsigned WD_LIMIT_DEFAULT = 1024;

    typedef struct packed {
        logic   valid;
        u64     addr;
        msize_t size;
        u8      strobe;
        u64     data;
    } dbus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u64   data;
    } dbus_resp_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        u64              addr;
        u8               strobe;
        u64              data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic ready;
        logic last;
        u64   data;
    } cbus_resp_t;

    typedef enum u2 {BR_IDLE, BR_BUSY, BR_DONE} bridge_state_t;

    function automatic logic is_write_req(input u8 strobe);
        return |strobe;
    endfunction

endpackage

// File: rtl/dbus_uncached_bridge_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when the limit is reached.
module sat_counter #(
    parameter int unsigned Width = 32,
    parameter int unsigned Limit = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic at_limit
);

    localparam logic [Width-1:0] LimitW = Width'(Limit);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LimitW)) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign at_limit = (count_q == LimitW);

endmodule

// File: rtl/dbus_uncached_bridge.sv
// Uncached data-bus bridge: turns one CPU data request into a single-beat cache-bus
// transaction, one outstanding at a time, with a sticky stall/protocol error flag.
module dbus_uncached_bridge
    import dbus_uncached_bridge_pkg::*;
#(
    parameter int unsigned WD_LIMIT = WD_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp,
    output logic       wd_err
);

    bridge_state_t state_q;
    cbus_req_t     creq_q;
    u64            rdata_q;
    logic          wd_err_q;

    logic accept;
    logic beat_done;
    logic beat_bad;
    logic wd_en;
    logic wd_at_limit;

    assign accept    = (state_q == BR_IDLE) && dreq.valid;
    assign beat_done = (state_q == BR_BUSY) && cresp.ready && cresp.last;
    assign beat_bad  = (state_q == BR_BUSY) && cresp.ready && !cresp.last;
    assign wd_en     = (state_q == BR_BUSY) && !beat_done;

    sat_counter #(
        .Width (32),
        .Limit (WD_LIMIT)
    ) u_wd_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .enable   (wd_en),
        .at_limit (wd_at_limit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BR_IDLE;
            creq_q   <= '0;
            rdata_q  <= '0;
            wd_err_q <= 1'b0;
        end else begin
            if (wd_at_limit || beat_bad) begin
                wd_err_q <= 1'b1;
            end
            unique case (state_q)
                BR_IDLE: begin
                    if (dreq.valid) begin
                        state_q         <= BR_BUSY;
                        creq_q.valid    <= 1'b1;
                        creq_q.is_write <= is_write_req(dreq.strobe);
                        creq_q.size     <= dreq.size;
                        creq_q.addr     <= dreq.addr;
                        creq_q.strobe   <= dreq.strobe;
                        creq_q.data     <= dreq.data;
                        creq_q.len      <= MLEN1;
                        creq_q.burst    <= AXI_BURST_FIXED;
                    end
                end
                BR_BUSY: begin
                    // A beat without last is a protocol error; it is dropped and we keep waiting.
                    if (beat_done) begin
                        rdata_q <= cresp.data;
                        creq_q  <= '0;
                        state_q <= BR_DONE;
                    end
                end
                BR_DONE: begin
                    state_q <= BR_IDLE;
                end
                default: begin
                    state_q <= BR_IDLE;
                    creq_q  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        dresp = '0;
        if (state_q == BR_DONE) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = rdata_q;
        end
    end

    assign creq   = creq_q;
    // Counter output is itself a register, so the flag shows up the cycle the limit is hit.
    assign wd_err = wd_err_q | wd_at_limit;

endmodule
